// File: rtl/arb8x1_4b.sv
// Round-robin scheduler for eight 4-bit requesters onto one valid/ready channel.
// Define ARB8X1_RR_EN for round-robin; otherwise fixed priority with i0 highest.
module arb8x1_4b (
   input  logic       clk,
   input  logic       rst,
   input  logic [7:0] req,
   input  logic [3:0] i0,
   input  logic [3:0] i1,
   input  logic [3:0] i2,
   input  logic [3:0] i3,
   input  logic [3:0] i4,
   input  logic [3:0] i5,
   input  logic [3:0] i6,
   input  logic [3:0] i7,
   input  logic       ready,
   output logic       valid,
   output logic [3:0] f,
   output logic       s2,
   output logic       s1,
   output logic       s0,
   output logic [7:0] gnt,
   output logic [7:0] ack
);

   typedef enum logic {IDLE, BUSY} state_t;

   state_t     state_q;
   logic       valid_q;
   logic [3:0] f_q;
   logic [2:0] sel_q;
   logic [7:0] gnt_q;
   logic [2:0] ptr;

   logic [3:0] din [8];
   logic       win_found_d;
   logic [2:0] win_d;
   logic [7:0] win_onehot_d;

   assign din[0] = i0;
   assign din[1] = i1;
   assign din[2] = i2;
   assign din[3] = i3;
   assign din[4] = i4;
   assign din[5] = i5;
   assign din[6] = i6;
   assign din[7] = i7;

   // Scan from the farthest offset down so the nearest set bit after ptr wins.
   always_comb begin
      win_found_d = 1'b0;
      win_d       = ptr;
      for (int j = 7; j >= 0; j--) begin
         if (req[ptr + 3'(j)]) begin
            win_found_d = 1'b1;
            win_d       = ptr + 3'(j);
         end
      end
   end

   for (genvar gi = 0; gi < 8; gi++) begin : g_onehot
      assign win_onehot_d[gi] = (win_d == 3'(gi));
   end

`ifdef ARB8X1_RR_EN
   logic [2:0] ptr_q;
   assign ptr = ptr_q;
`else
   assign ptr = 3'd0;
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         valid_q <= 1'b0;
         f_q     <= 4'b0000;
         sel_q   <= 3'b000;
         gnt_q   <= 8'h00;
`ifdef ARB8X1_RR_EN
         ptr_q   <= 3'd0;
`endif
      end else begin
         case (state_q)
            IDLE: begin
               if (win_found_d) begin
                  sel_q   <= win_d;
                  f_q     <= din[win_d];
                  gnt_q   <= win_onehot_d;
                  valid_q <= 1'b1;
                  state_q <= BUSY;
               end
            end
            BUSY: begin
               // Word, select and grant stay frozen until the consumer takes it.
               if (ready) begin
                  valid_q <= 1'b0;
                  gnt_q   <= 8'h00;
`ifdef ARB8X1_RR_EN
                  ptr_q   <= sel_q + 3'd1;
`endif
                  state_q <= IDLE;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign valid        = valid_q;
   assign f            = f_q;
   assign {s2, s1, s0} = sel_q;
   assign gnt          = gnt_q;
   assign ack          = (valid_q && ready) ? gnt_q : 8'h00;

endmodule

// File: tb/tb_arb8x1_4b.sv
// Directed self-checking bench for arb8x1_4b; expectations follow ARB8X1_RR_EN.
module tb_arb8x1_4b;

   logic       clk = 1'b0;
   logic       rst;
   logic [7:0] req;
   logic [3:0] i0, i1, i2, i3, i4, i5, i6, i7;
   logic       ready;
   logic       valid;
   logic [3:0] f;
   logic       s2, s1, s0;
   logic [7:0] gnt;
   logic [7:0] ack;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   arb8x1_4b dut (
      .clk(clk), .rst(rst), .req(req),
      .i0(i0), .i1(i1), .i2(i2), .i3(i3), .i4(i4), .i5(i5), .i6(i6), .i7(i7),
      .ready(ready), .valid(valid), .f(f), .s2(s2), .s1(s1), .s0(s0),
      .gnt(gnt), .ack(ack)
   );

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic check_out(input string tag, input logic v, input logic [3:0] fv,
                            input logic [2:0] sel, input logic [7:0] g, input logic [7:0] a);
      check({tag, ".valid"}, 32'(valid), 32'(v));
      check({tag, ".f"},     32'(f), 32'(fv));
      check({tag, ".sel"},   32'({s2, s1, s0}), 32'(sel));
      check({tag, ".gnt"},   32'(gnt), 32'(g));
      check({tag, ".ack"},   32'(ack), 32'(a));
      $display("step %-14s valid=%0d f=%h sel=%0d gnt=%h ack=%h", tag, valid, f, {s2, s1, s0}, gnt, ack);
   endtask

   initial begin
      rst = 1'b1; req = 8'hFF; ready = 1'b1;
      i0 = 4'h1; i1 = 4'h2; i2 = 4'h3; i3 = 4'h4;
      i4 = 4'h0; i5 = 4'h6; i6 = 4'h7; i7 = 4'h8;

      // Reset held two cycles with every requester active.
      step(); step();
      check_out("reset", 1'b0, 4'h0, 3'd0, 8'h00, 8'h00);

      // Single request from requester 4.
      rst = 1'b0; req = 8'b0001_0000; i4 = 4'hA; ready = 1'b1;
      step();
      check_out("single", 1'b1, 4'hA, 3'd4, 8'h10, 8'h10);
      req = 8'h00;
      step();
      check_out("single_done", 1'b0, 4'hA, 3'd4, 8'h00, 8'h00);

      // Backpressure: word 5 captured, input and req change while stalled.
      req = 8'h04; i2 = 4'h5; ready = 1'b0;
      step();
      check_out("bp_grant", 1'b1, 4'h5, 3'd2, 8'h04, 8'h00);
      i2 = 4'hF; req = 8'hFF;
      for (int c = 0; c < 4; c++) begin
         step();
         check_out("bp_hold", 1'b1, 4'h5, 3'd2, 8'h04, 8'h00);
      end
      ready = 1'b1;
      #1;
      check_out("bp_ack", 1'b1, 4'h5, 3'd2, 8'h04, 8'h04);
      req = 8'h00;
      step();
      check_out("bp_done", 1'b0, 4'h5, 3'd2, 8'h00, 8'h00);

      // Return pointer to 0 before the fairness run.
      rst = 1'b1;
      step();
      rst = 1'b0;
      check_out("reset2", 1'b0, 4'h0, 3'd0, 8'h00, 8'h00);
      i0 = 4'h1; i1 = 4'h2; i2 = 4'h3; i3 = 4'h4;
      i4 = 4'h5; i5 = 4'h6; i6 = 4'h7; i7 = 4'h8;

`ifdef ARB8X1_RR_EN
      req = 8'hFF; ready = 1'b1;
      for (int k = 0; k < 9; k++) begin
         logic [2:0] w;
         w = 3'(k % 8);
         step();
         check_out("rr_grant", 1'b1, 4'(w) + 4'h1, w, 8'h01 << w, 8'h01 << w);
         step();
         check("rr_gap.valid", 32'(valid), 32'd0);
      end
`else
      req = 8'b1000_0001; ready = 1'b1;
      for (int k = 0; k < 4; k++) begin
         step();
         check_out("fp_grant", 1'b1, 4'h1, 3'd0, 8'h01, 8'h01);
         step();
         check("fp_gap.valid", 32'(valid), 32'd0);
      end
`endif

      // Reset mid-transfer while requester 3 is granted.
      rst = 1'b1; req = 8'h00;
      step();
      rst = 1'b0; req = 8'h08; i3 = 4'h7; ready = 1'b0;
      step();
      check_out("mid_grant", 1'b1, 4'h7, 3'd3, 8'h08, 8'h00);
      ready = 1'b1; rst = 1'b1; req = 8'h00;
      #1;
      check("mid_ack", 32'(ack), 32'h08);
      step();
      check_out("mid_reset", 1'b0, 4'h0, 3'd0, 8'h00, 8'h00);
      // Pointer must restart at 0: bits 2 and 5 set, 2 wins either way from 0.
      rst = 1'b0; req = 8'h24; ready = 1'b0;
      step();
      check_out("after_rst", 1'b1, 4'h3, 3'd2, 8'h04, 8'h00);
      ready = 1'b1; req = 8'h00;
      step();

      // Grant 5 so the round-robin pointer lands on 6, then test wrap-around.
      req = 8'h20;
      step();
      check_out("grant5", 1'b1, 4'h6, 3'd5, 8'h20, 8'h20);
      req = 8'h00;
      step();
      req = 8'b0000_0011; ready = 1'b0;
      step();
      check_out("wrap", 1'b1, 4'h1, 3'd0, 8'h01, 8'h00);
      ready = 1'b1; req = 8'h00;
      step();
      check_out("wrap_done", 1'b0, 4'h1, 3'd0, 8'h00, 8'h00);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
